// File: rtl/fir_reload_pkg.sv
// Shared widths and FSM encoding for the FIR coefficient reload block.
package fir_reload_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned CFG_W    = 8;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned NUM_TAPS = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_FETCH  = 2'd1;
  localparam state_t ST_STREAM = 2'd2;
  localparam state_t ST_CONFIG = 2'd3;

endpackage

// File: rtl/fir_coeff_ram.sv
// Simple dual-port coefficient store: one write port, one read port with a
// registered read. Contents are deliberately not reset.
module fir_coeff_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              aclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge aclk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fir_coeff_reloader.sv
// Streams one stored coefficient set out on an AXI-Stream reload channel,
// then announces the set on a config channel.
module fir_coeff_reloader #(
  parameter int unsigned DATA_W   = fir_reload_pkg::DATA_W,
  parameter int unsigned CFG_W    = fir_reload_pkg::CFG_W,
  parameter int unsigned SEL_W    = fir_reload_pkg::SEL_W,
  parameter int unsigned NUM_TAPS = fir_reload_pkg::NUM_TAPS
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        wr_en,
  input  logic [SEL_W-1:0]            wr_set,
  input  logic [$clog2(NUM_TAPS)-1:0] wr_idx,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_drop,
  input  logic                        reload_req,
  input  logic [SEL_W-1:0]            reload_set,
  output logic                        busy,
  output logic                        done,
  output logic                        m_reload_tvalid,
  output logic [DATA_W-1:0]           m_reload_tdata,
  output logic                        m_reload_tlast,
  input  logic                        m_reload_tready,
  output logic                        m_cfg_tvalid,
  output logic [CFG_W-1:0]            m_cfg_tdata,
  input  logic                        m_cfg_tready
);

  import fir_reload_pkg::*;

  localparam int unsigned IDX_W  = $clog2(NUM_TAPS);
  localparam int unsigned ADDR_W = SEL_W + IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   set_q, set_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wr_drop_q, wr_drop_d;
  logic               tvalid_q, tvalid_d;
  logic               tlast_q, tlast_d;
  logic               cfg_tvalid_q, cfg_tvalid_d;
  logic [CFG_W-1:0]   cfg_tdata_q, cfg_tdata_d;

  logic               drop_c;
  logic               ram_we_c;
  logic               rd_en_c;
  logic [IDX_W-1:0]   rd_idx_c;
  logic [IDX_W-1:0]   idx_inc_c;
  logic [DATA_W-1:0]  rd_data_c;

  // Writes into the set being streamed (or about to be) would corrupt the beat order.
  always_comb begin
    drop_c   = wr_en &&
               ((busy_q && (wr_set == set_q)) ||
                ((state_q == ST_IDLE) && reload_req && (wr_set == reload_set)));
    ram_we_c = wr_en && !drop_c;
  end

  fir_coeff_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .aclk  (aclk),
    .we    (ram_we_c),
    .waddr ({wr_set, wr_idx}),
    .wdata (wr_data),
    .re    (rd_en_c),
    .raddr ({set_q, rd_idx_c}),
    .rdata (rd_data_c)
  );

  // Next-state logic: the read for beat n+1 is issued on beat n's handshake,
  // so the RAM output register doubles as the stalled-beat holding register.
  always_comb begin
    state_d      = state_q;
    set_d        = set_q;
    idx_d        = idx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    wr_drop_d    = drop_c;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    cfg_tvalid_d = cfg_tvalid_q;
    cfg_tdata_d  = cfg_tdata_q;
    rd_en_c      = 1'b0;
    idx_inc_c    = idx_q + IDX_W'(1);
    rd_idx_c     = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (reload_req) begin
          set_d   = reload_set;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        rd_en_c  = 1'b1;
        tvalid_d = 1'b1;
        tlast_d  = (idx_q == LAST_IDX);
        state_d  = ST_STREAM;
      end
      ST_STREAM: begin
        if (m_reload_tready) begin
          if (idx_q == LAST_IDX) begin
            tvalid_d     = 1'b0;
            tlast_d      = 1'b0;
            cfg_tvalid_d = 1'b1;
            cfg_tdata_d  = CFG_W'(set_q);
            state_d      = ST_CONFIG;
          end else begin
            idx_d    = idx_inc_c;
            rd_en_c  = 1'b1;
            rd_idx_c = idx_inc_c;
            tlast_d  = (idx_inc_c == LAST_IDX);
          end
        end
      end
      ST_CONFIG: begin
        if (m_cfg_tready) begin
          cfg_tvalid_d = 1'b0;
          done_d       = 1'b1;
          busy_d       = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      set_q        <= '0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_drop_q    <= 1'b0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      cfg_tvalid_q <= 1'b0;
      cfg_tdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      set_q        <= set_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wr_drop_q    <= wr_drop_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      cfg_tvalid_q <= cfg_tvalid_d;
      cfg_tdata_q  <= cfg_tdata_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign wr_drop         = wr_drop_q;
  assign m_reload_tvalid = tvalid_q;
  // RAM output has no reset; gate it so tdata reads zero whenever no beat is offered.
  assign m_reload_tdata  = rd_data_c & {DATA_W{tvalid_q}};
  assign m_reload_tlast  = tlast_q;
  assign m_cfg_tvalid    = cfg_tvalid_q;
  assign m_cfg_tdata     = cfg_tdata_q;

endmodule

// File: tb/tb_fir_coeff_reloader.sv
// Randomised self-checking bench for fir_coeff_reloader against a
// transaction-level model of the reload sequence.
module tb_fir_coeff_reloader;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;
  localparam int unsigned SW = 4;
  localparam int unsigned NT = 32;
  localparam int unsigned IW = 5;
  localparam int unsigned NS = 16;

  logic          aclk;
  logic          aresetn;
  logic          wr_en;
  logic [SW-1:0] wr_set;
  logic [IW-1:0] wr_idx;
  logic [DW-1:0] wr_data;
  logic          wr_drop;
  logic          reload_req;
  logic [SW-1:0] reload_set;
  logic          busy;
  logic          done;
  logic          m_reload_tvalid;
  logic [DW-1:0] m_reload_tdata;
  logic          m_reload_tlast;
  logic          m_reload_tready;
  logic          m_cfg_tvalid;
  logic [CW-1:0] m_cfg_tdata;
  logic          m_cfg_tready;

  fir_coeff_reloader #(
    .DATA_W   (DW),
    .CFG_W    (CW),
    .SEL_W    (SW),
    .NUM_TAPS (NT)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .wr_en           (wr_en),
    .wr_set          (wr_set),
    .wr_idx          (wr_idx),
    .wr_data         (wr_data),
    .wr_drop         (wr_drop),
    .reload_req      (reload_req),
    .reload_set      (reload_set),
    .busy            (busy),
    .done            (done),
    .m_reload_tvalid (m_reload_tvalid),
    .m_reload_tdata  (m_reload_tdata),
    .m_reload_tlast  (m_reload_tlast),
    .m_reload_tready (m_reload_tready),
    .m_cfg_tvalid    (m_cfg_tvalid),
    .m_cfg_tdata     (m_cfg_tdata),
    .m_cfg_tready    (m_cfg_tready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: a busy flag, the set, how many beats went out,
  // a start-up delay countdown and a config-pending flag.
  int m_mem [NS][NT];
  int init_v [NS][NT];
  bit m_busy, m_cfg, e_done, e_drop, mdl_drop;
  int m_set, m_cnt, m_wait;

  initial begin
    m_busy = 0; m_cfg = 0; e_done = 0; e_drop = 0; m_set = 0; m_cnt = 0; m_wait = 0;
    forever begin
      @(posedge aclk or negedge aresetn);
      if (!aresetn) begin
        m_busy = 0; m_cfg = 0; e_done = 0; e_drop = 0; m_cnt = 0; m_wait = 0;
      end else begin
        e_done = 0;
        e_drop = 0;
        if (wr_en) begin
          mdl_drop = (m_busy && int'(wr_set) == m_set) ||
                     (!m_busy && reload_req && wr_set == reload_set);
          if (mdl_drop) e_drop = 1;
          else m_mem[wr_set][wr_idx] = int'(wr_data);
        end
        if (!m_busy) begin
          if (reload_req) begin
            m_busy = 1; m_set = int'(reload_set); m_cnt = 0; m_wait = 1;
          end
        end else if (m_cfg) begin
          if (m_cfg_tready) begin
            m_busy = 0; m_cfg = 0; e_done = 1;
          end
        end else if (m_wait > 0) begin
          m_wait--;
        end else if (m_reload_tready) begin
          if (m_cnt == NT - 1) m_cfg = 1;
          else m_cnt++;
        end
      end
    end
  end

  // Per-cycle comparison plus beat collection.
  logic [DW-1:0] got_q[$];
  logic [CW-1:0] cfg_q[$];
  int tlast_cnt, done_cnt, cfg_hold;
  bit p_tv, p_tr, p_last, e_tv;
  logic [DW-1:0] p_data;

  initial begin
    tlast_cnt = 0; done_cnt = 0; cfg_hold = 0; p_tv = 0; p_tr = 0; p_last = 0; p_data = '0;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        e_tv = m_busy && !m_cfg && m_wait == 0;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("wr_drop", 32'(wr_drop), 32'(e_drop));
        chk("reload_tvalid", 32'(m_reload_tvalid), 32'(e_tv));
        chk("cfg_tvalid", 32'(m_cfg_tvalid), 32'(m_cfg));
        chk("valid_exclusive", 32'(m_reload_tvalid & m_cfg_tvalid), 32'd0);
        if (e_tv) begin
          chk("reload_tdata", 32'(m_reload_tdata), 32'(m_mem[m_set][m_cnt]));
          chk("reload_tlast", 32'(m_reload_tlast), 32'(m_cnt == NT - 1));
        end else begin
          chk("reload_tlast_idle", 32'(m_reload_tlast), 32'd0);
        end
        if (m_cfg) chk("cfg_tdata", 32'(m_cfg_tdata), 32'(m_set));
        if (p_tv && !p_tr && m_reload_tvalid) begin
          chk("stall_tdata", 32'(m_reload_tdata), 32'(p_data));
          chk("stall_tlast", 32'(m_reload_tlast), 32'(p_last));
        end
        if (m_reload_tvalid && m_reload_tready) begin
          got_q.push_back(m_reload_tdata);
          if (m_reload_tlast) tlast_cnt++;
        end
        if (m_cfg_tvalid && m_cfg_tready) cfg_q.push_back(m_cfg_tdata);
        if (m_cfg_tvalid && !m_cfg_tready) cfg_hold++;
        if (done) done_cnt++;
        p_tv = m_reload_tvalid; p_tr = m_reload_tready;
        p_data = m_reload_tdata; p_last = m_reload_tlast;
      end else begin
        p_tv = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic wr(input int s, input int i, input int d);
    wr_en = 1'b1; wr_set = SW'(s); wr_idx = IW'(i); wr_data = DW'(d);
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic clear_obs();
    got_q.delete(); cfg_q.delete(); tlast_cnt = 0; cfg_hold = 0;
  endtask

  // mode 0: both readies high; 1: reload ready random; 2: cfg ready held low 10 cycles
  task automatic wait_done(input int mode, input int budget, input string name);
    int start;
    bit ok;
    start = done_cnt;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != start) begin
        ok = 1;
        break;
      end
      case (mode)
        1:       begin m_reload_tready = 1'($urandom_range(0, 1)); m_cfg_tready = 1'b1; end
        2:       begin m_reload_tready = 1'b1; m_cfg_tready = 1'(cfg_hold >= 10); end
        default: begin m_reload_tready = 1'b1; m_cfg_tready = 1'b1; end
      endcase
      cyc(1);
    end
    chk({name, "_done_timeout"}, 32'(ok), 32'd1);
    m_reload_tready = 1'b1;
    m_cfg_tready = 1'b1;
  endtask

  task automatic start_reload(input int s);
    reload_req = 1'b1; reload_set = SW'(s);
    cyc(1);
    reload_req = 1'b0;
  endtask

  task automatic check_set3(input string name, input int d0);
    chk({name, "_beats"}, 32'(got_q.size()), 32'(NT));
    for (int k = 0; k < got_q.size() && k < NT; k++)
      chk({name, "_beat"}, 32'(got_q[k]), 32'h0100 + 32'(k));
    chk({name, "_tlast_cnt"}, 32'(tlast_cnt), 32'd1);
    chk({name, "_cfg_cnt"}, 32'(cfg_q.size()), 32'd1);
    if (cfg_q.size() > 0) chk({name, "_cfg_data"}, 32'(cfg_q[0]), 32'h03);
    chk({name, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    chk({name, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  int d0;
  bit sent9;

  initial begin
    aresetn = 1'b0; wr_en = 1'b0; wr_set = '0; wr_idx = '0; wr_data = '0;
    reload_req = 1'b0; reload_set = '0; m_reload_tready = 1'b1; m_cfg_tready = 1'b1;
    cyc(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_drop", 32'(wr_drop), 32'd0);
    chk("rst_tvalid", 32'(m_reload_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_reload_tlast), 32'd0);
    chk("rst_tdata", 32'(m_reload_tdata), 32'd0);
    chk("rst_cfg_tvalid", 32'(m_cfg_tvalid), 32'd0);
    chk("rst_cfg_tdata", 32'(m_cfg_tdata), 32'd0);
    aresetn = 1'b1;
    cyc(2);

    for (int s = 0; s < NS; s++)
      for (int k = 0; k < NT; k++) begin
        init_v[s][k] = (s == 3) ? 32'h0100 + k : int'($urandom_range(0, 16'hFFFF));
        wr(s, k, init_v[s][k]);
      end
    cyc(2);

    // Full-rate reload of set 3 with literal latency pins.
    clear_obs(); d0 = done_cnt;
    m_reload_tready = 1'b1; m_cfg_tready = 1'b1;
    start_reload(3);
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_tvalid_c1", 32'(m_reload_tvalid), 32'd0);
    cyc(1);
    chk("lat_tvalid_c2", 32'(m_reload_tvalid), 32'd1);
    chk("lat_tdata_c2", 32'(m_reload_tdata), 32'h0100);
    wait_done(0, 200, "full");
    check_set3("full", d0);

    // Random backpressure on the reload stream.
    clear_obs(); d0 = done_cnt;
    start_reload(3);
    wait_done(1, 500, "stall");
    check_set3("stall", d0);

    // Config channel held off for 10 cycles.
    clear_obs(); d0 = done_cnt;
    m_cfg_tready = 1'b0;
    start_reload(3);
    wait_done(2, 300, "cfgwait");
    check_set3("cfgwait", d0);
    chk("cfgwait_hold", 32'(cfg_hold), 32'd10);

    // Writes during a set 3 stream: set 3 dropped, set 7 accepted.
    clear_obs(); d0 = done_cnt;
    start_reload(3);
    cyc(4);
    wr(3, 5, 16'hDEAD);
    chk("drop_set3", 32'(wr_drop), 32'd1);
    wr(7, 5, 16'hBEEF);
    chk("drop_set7", 32'(wr_drop), 32'd0);
    wait_done(0, 200, "wrmid");
    check_set3("wrmid", d0);
    clear_obs();
    start_reload(7);
    wait_done(0, 200, "rb7");
    chk("rb7_beats", 32'(got_q.size()), 32'(NT));
    if (got_q.size() > 5) chk("rb7_idx5", 32'(got_q[5]), 32'hBEEF);
    if (got_q.size() > 4) chk("rb7_idx4", 32'(got_q[4]), 32'(init_v[7][4]));

    // Write to the set whose reload is accepted in the same cycle.
    clear_obs();
    reload_req = 1'b1; reload_set = 4'd5;
    wr_en = 1'b1; wr_set = 4'd5; wr_idx = '0; wr_data = 16'h5555;
    cyc(1);
    reload_req = 1'b0; wr_en = 1'b0;
    chk("same_cycle_drop", 32'(wr_drop), 32'd1);
    wait_done(0, 200, "same5");
    if (got_q.size() > 0) chk("same5_idx0", 32'(got_q[0]), 32'(init_v[5][0]));

    // Ignored second request, then reset mid-stream after 10 beats.
    clear_obs(); d0 = done_cnt; sent9 = 0;
    start_reload(3);
    for (int i = 0; i < 200; i++) begin
      if (got_q.size() >= 10) break;
      if (got_q.size() >= 4 && !sent9) begin
        reload_req = 1'b1; reload_set = 4'd9; sent9 = 1;
      end else begin
        reload_req = 1'b0;
      end
      cyc(1);
    end
    reload_req = 1'b0;
    chk("abort_beats_before", 32'(got_q.size()), 32'd10);
    aresetn = 1'b0;
    #1;
    chk("abort_tvalid", 32'(m_reload_tvalid), 32'd0);
    chk("abort_tlast", 32'(m_reload_tlast), 32'd0);
    chk("abort_tdata", 32'(m_reload_tdata), 32'd0);
    chk("abort_cfg_tvalid", 32'(m_cfg_tvalid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    cyc(3);
    aresetn = 1'b1;
    cyc(3);
    chk("abort_tlast_cnt", 32'(tlast_cnt), 32'd0);
    chk("abort_cfg_cnt", 32'(cfg_q.size()), 32'd0);
    chk("abort_done_cnt", 32'(done_cnt - d0), 32'd0);
    for (int k = 0; k < got_q.size() && k < 10; k++)
      chk("abort_beat", 32'(got_q[k]), 32'h0100 + 32'(k));
    clear_obs(); d0 = done_cnt;
    start_reload(3);
    wait_done(0, 200, "after_rst");
    check_set3("after_rst", d0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      wr_en = 1'($urandom_range(0, 9) < 3);
      wr_set = SW'($urandom_range(0, NS - 1));
      wr_idx = IW'($urandom_range(0, NT - 1));
      wr_data = DW'($urandom_range(0, 16'hFFFF));
      reload_req = 1'($urandom_range(0, 7) == 0);
      reload_set = SW'($urandom_range(0, NS - 1));
      m_reload_tready = 1'($urandom_range(0, 1));
      m_cfg_tready = 1'($urandom_range(0, 1));
      cyc(1);
    end
    wr_en = 1'b0; reload_req = 1'b0; m_reload_tready = 1'b1; m_cfg_tready = 1'b1;
    for (int i = 0; i < 100 && busy; i++) cyc(1);
    cyc(2);
    chk("final_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
